// File: rtl/mult_batch_writer_if.sv
// Handshake and FIFO-side signal bundle for mult_batch_writer.
// The slave modport is the writer's view; master is the surrounding producer/FIFO/multiplier side.
interface mult_batch_writer_if;
    logic        start_sig;
    logic [4:0]  job_count;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_ready;
    logic        write_req;
    logic [15:0] fifo_write_data;
    logic [4:0]  left_sig;
    logic        done_sig;
    logic [15:0] product;
    logic        busy;
    logic        batch_done;
    logic [20:0] sum;
    logic [4:0]  result_count;

    modport slave (
        input  start_sig, job_count, in_valid, in_a, in_b, left_sig, done_sig, product,
        output in_ready, write_req, fifo_write_data, busy, batch_done, sum, result_count
    );

    modport master (
        output start_sig, job_count, in_valid, in_a, in_b, left_sig, done_sig, product,
        input  in_ready, write_req, fifo_write_data, busy, batch_done, sum, result_count
    );
endinterface

// File: rtl/mult_batch_writer.sv
// Batch producer for the 16-deep multiplier operand FIFO: issues up to 16 operand pairs
// without overflowing the FIFO, then accumulates returned products and pulses on completion.
module mult_batch_writer (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_batch_writer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [4:0]  sent_q, sent_d;
    logic [4:0]  result_count_q, result_count_d;
    logic [20:0] sum_q, sum_d;
    logic        write_req_q, write_req_d;
    logic [15:0] wdata_q, wdata_d;

    logic        ready;
    logic        accept;
    logic        collect;
    logic        start_ok;

    // left_sig lags the write strobe by a cycle, so an in-flight write claims one slot.
    assign ready    = (state_q == RUN) && (sent_q != count_q)
                      && (bus.left_sig > {4'b0, write_req_q});
    assign accept   = ready && bus.in_valid;
    assign collect  = ((state_q == RUN) || (state_q == DRAIN)) && bus.done_sig
                      && (result_count_q != count_q);
    assign start_ok = bus.start_sig && (bus.job_count != 5'd0) && (bus.job_count <= 5'd16);

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        sent_d         = sent_q;
        result_count_d = result_count_q;
        sum_d          = sum_q;
        write_req_d    = 1'b0;
        wdata_d        = wdata_q;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d        = RUN;
                    count_d        = bus.job_count;
                    sent_d         = '0;
                    result_count_d = '0;
                    sum_d          = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    sent_d      = sent_q + 5'd1;
                    write_req_d = 1'b1;
                    wdata_d     = {bus.in_a, bus.in_b};
                    if (sent_q + 5'd1 == count_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (result_count_q == count_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Collecting the final product wins over the RUN->DRAIN step so DONE follows directly.
        if (collect) begin
            sum_d          = sum_q + {5'b0, bus.product};
            result_count_d = result_count_q + 5'd1;
            if (result_count_q + 5'd1 == count_q) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            count_q        <= '0;
            sent_q         <= '0;
            result_count_q <= '0;
            sum_q          <= '0;
            write_req_q    <= 1'b0;
            wdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            sent_q         <= sent_d;
            result_count_q <= result_count_d;
            sum_q          <= sum_d;
            write_req_q    <= write_req_d;
            wdata_q        <= wdata_d;
        end
    end

    assign bus.in_ready        = ready;
    assign bus.write_req       = write_req_q;
    assign bus.fifo_write_data = wdata_q;
    assign bus.busy            = (state_q == RUN) || (state_q == DRAIN);
    assign bus.batch_done      = (state_q == DONE);
    assign bus.sum             = sum_q;
    assign bus.result_count    = result_count_q;

endmodule
